sar_search: RTL and testbench

SAR_SEARCH -- requirements
Module: sar_search

---
 rtl/sar_search.sv | 107 ++++++++++
 tb/tb_sar_search.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
// Successive-approximation search: recovers an unknown value by walking a trial
// from MSB to LSB against an external "unknown > trial" comparator.
module sar_search #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  output logic [WIDTH-1:0] o_trial,
  input  logic             i_gt_in,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_result,
  output logic             o_result_valid,
  input  logic             i_result_ready
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_INIT = (SETTLE > 0) ? CW'(SETTLE - 1) : '0;
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  // With SETTLE=0 each bit window is just the sampling cycle.
  localparam state_t WINDOW_START = (SETTLE > 0) ? S_SETTLE : S_SAMPLE;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mask;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_trial;
  logic             r_busy;
  logic [WIDTH-1:0] r_result;
  logic             r_valid;

  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_mask_next;

  assign w_acc_next  = i_gt_in ? (r_acc | r_mask) : r_acc;
  assign w_mask_next = r_mask >> 1;

  // NOTE: all state uses non-blocking assignments so every register sees the
  // pre-edge values of its neighbours; reset is synchronous inside this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_mask  <= '0;
      r_cnt   <= '0;
      r_trial <= '0;
      r_busy  <= 1'b0;
      r_result <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_acc   <= '0;
            r_mask  <= MSB;
            r_trial <= MSB - WIDTH'(1);
            r_cnt   <= CNT_INIT;
            r_busy  <= 1'b1;
            r_state <= WINDOW_START;
          end
        end
        S_SETTLE: begin
          if (r_cnt == '0) r_state <= S_SAMPLE;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        S_SAMPLE: begin
          r_acc <= w_acc_next;
          if (r_mask[0]) begin
            r_result <= w_acc_next;
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
            r_trial  <= '0;
            r_state  <= S_DONE;
          end else begin
            // Next trial: decided bits kept, current bit clear, lower bits set.
            r_mask  <= w_mask_next;
            r_trial <= w_acc_next | (w_mask_next - WIDTH'(1));
            r_cnt   <= CNT_INIT;
            r_state <= WINDOW_START;
          end
        end
        S_DONE: begin
          if (i_result_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_trial        = r_trial;
  assign o_busy         = r_busy;
  assign o_result       = r_result;
  assign o_result_valid = r_valid;

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: two builds (SETTLE=1 and SETTLE=0) driven by a
// comparator model, with a queue-based scoreboard checked by a monitor.
module tb_sar_search;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           start [2];
  logic           ready [2];
  logic [W-1:0]   u     [2];
  logic [W-1:0]   trial [2];
  logic [W-1:0]   result[2];
  logic           busy  [2];
  logic           valid [2];
  logic           gt    [2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int uv;
    int acc;
  } exp_t;

  exp_t sb  [2][$];
  int   tlog[2][$];

  sar_search #(.WIDTH(W), .SETTLE(1)) u_dut_s1 (
    .clk(clk), .rst(rst), .i_start(start[0]), .o_trial(trial[0]), .i_gt_in(gt[0]),
    .o_busy(busy[0]), .o_result(result[0]), .o_result_valid(valid[0]),
    .i_result_ready(ready[0])
  );

  sar_search #(.WIDTH(W), .SETTLE(0)) u_dut_s0 (
    .clk(clk), .rst(rst), .i_start(start[1]), .o_trial(trial[1]), .i_gt_in(gt[1]),
    .o_busy(busy[1]), .o_result(result[1]), .o_result_valid(valid[1]),
    .i_result_ready(ready[1])
  );

  // External comparator: unknown on "a", trial on "b".
  assign gt[0] = u[0] > trial[0];
  assign gt[1] = u[1] > trial[1];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int settle_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  // Binary-search view: while deciding bit b, the bits above b already match
  // the unknown and the trial sits just below the midpoint of what remains.
  function automatic int exp_trial(input int uv, input int b);
    return ((uv >> (b + 1)) << (b + 1)) | ((1 << b) - 1);
  endfunction

  logic pv[2] = '{1'b0, 1'b0};
  int   last_u[2] = '{0, 0};

  always @(negedge clk) begin : monitor
    exp_t e;
    int   s, l, idx;
    for (int k = 0; k < 2; k++) begin
      if (valid[k] && !pv[k]) begin
        if (sb[k].size() == 0) begin
          check($sformatf("unexpected_valid[%0d]", k), 1, 0);
        end else begin
          e = sb[k].pop_front();
          s = settle_of(k);
          l = W * (s + 1);
          check($sformatf("result[%0d] u=%0d", k, e.uv), int'(result[k]), e.uv);
          check($sformatf("latency[%0d]", k), cyc - e.acc, l);
          check($sformatf("busy_at_valid[%0d]", k), int'(busy[k]), 0);
          check($sformatf("trial_samples[%0d]", k), tlog[k].size(), l);
          if (tlog[k].size() == l) begin
            for (int i = 0; i < l; i++) begin
              idx = W - 1 - i / (s + 1);
              check($sformatf("trial[%0d] u=%0d bit=%0d", k, e.uv, idx),
                    tlog[k][i], exp_trial(e.uv, idx));
            end
          end
          last_u[k] = e.uv;
        end
      end else if (valid[k]) begin
        check($sformatf("hold_result[%0d]", k), int'(result[k]), last_u[k]);
        check($sformatf("hold_trial[%0d]", k), int'(trial[k]), 0);
      end
      if (busy[k] && !valid[k]) tlog[k].push_back(int'(trial[k]));
      if (!busy[k]) tlog[k].delete();
      pv[k] = valid[k];
    end
  end

  task automatic run_search(input int k, input int uv, input int hold, input bit pulse);
    int   l;
    int   n;
    exp_t e;
    l = W * (settle_of(k) + 1);
    u[k]     = W'(uv);
    start[k] = 1'b1;
    @(posedge clk);
    #1;
    e.uv  = uv;
    e.acc = cyc;
    sb[k].push_back(e);
    start[k] = 1'b0;
    if (pulse) begin
      for (int i = 0; i < l - 2; i++) begin
        @(negedge clk);
        start[k] = (i % 2 == 0);
      end
      @(negedge clk);
      start[k] = 1'b0;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid[k] && n < 60);
    if (!valid[k]) begin
      check($sformatf("valid_timeout[%0d]", k), 0, 1);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      start[k] = (i % 2 == 0);
      @(negedge clk);
    end
    ready[k] = 1'b1;
    start[k] = 1'b1;
    @(posedge clk);
    #1;
    ready[k] = 1'b0;
    start[k] = 1'b0;
    @(negedge clk);
    check($sformatf("post_hs_valid[%0d]", k), int'(valid[k]), 0);
    check($sformatf("post_hs_busy[%0d]", k), int'(busy[k]), 0);
    check($sformatf("post_hs_trial[%0d]", k), int'(trial[k]), 0);
    @(negedge clk);
    check($sformatf("idle_busy[%0d]", k), int'(busy[k]), 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = '{1'b0, 1'b0};
    ready = '{1'b0, 1'b0};
    u     = '{'0, '0};
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_trial[%0d]", k), int'(trial[k]), 0);
      check($sformatf("rst_busy[%0d]", k), int'(busy[k]), 0);
      check($sformatf("rst_result[%0d]", k), int'(result[k]), 0);
      check($sformatf("rst_valid[%0d]", k), int'(valid[k]), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    run_search(0, 0, 0, 1'b1);
    run_search(0, 11, 5, 1'b0);
    run_search(0, 15, 0, 1'b1);
    for (int i = 0; i < 8; i++)
      run_search(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b1);

    // Abort a search partway through its second bit window.
    u[0]     = 4'd5;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_trial", int'(trial[0]), 0);
    check("abort_busy", int'(busy[0]), 0);
    check("abort_valid", int'(valid[0]), 0);
    check("abort_result", int'(result[0]), 0);
    run_search(0, 6, 0, 1'b0);

    run_search(1, 9, 0, 1'b0);
    run_search(1, 0, 2, 1'b0);
    run_search(1, 15, 0, 1'b0);
    for (int i = 0; i < 6; i++)
      run_search(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b0);

    repeat (3) @(negedge clk);
    check("sb_empty_s1", sb[0].size(), 0);
    check("sb_empty_s0", sb[1].size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
